// File: rtl/spi_word_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : spi_word_multiplier
// Description : Splits each received SPI word into two unsigned operands and
//               multiplies them with a sequential shift-add engine. The
//               product is streamed MSB byte first over a valid/ready byte
//               handshake. Status outputs report busy, done and dropped words.
//               Optional macro SPI_MULT_PENDING_BUF_EN adds a one-entry
//               pending-word buffer so a word arriving while busy is kept
//               rather than dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_word_multiplier #(
    parameter int OP_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2*OP_WIDTH-1:0]   rx_data,
    input  logic                    rx_valid,
    output logic [7:0]              tx_byte,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun,
    input  logic                    clear_overrun
);

    localparam int c_W2 = 2 * OP_WIDTH;
    localparam int c_NB = c_W2 / 8;
    localparam int c_CW = (OP_WIDTH > 1) ? $clog2(OP_WIDTH) : 1;
    localparam int c_IW = (c_NB > 1) ? $clog2(c_NB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [OP_WIDTH-1:0]    a_q, a_d;
    logic [OP_WIDTH-1:0]    b_q, b_d;
    logic [c_W2-1:0]        acc_q, acc_d;
    logic [c_CW-1:0]        cnt_q, cnt_d;
    logic [c_IW-1:0]        idx_q, idx_d;
    logic [7:0]             tx_byte_q, tx_byte_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   overrun_q, overrun_d;
`ifdef SPI_MULT_PENDING_BUF_EN
    logic [c_W2-1:0]        pbuf_q, pbuf_d;
    logic                   pbuf_valid_q, pbuf_valid_d;
`endif

    logic [c_W2-1:0]        w_acc_step;
    logic [c_W2-1:0]        w_byte_shift;
    logic [c_IW-1:0]        w_idx_next;
    logic                   w_hs;
    logic                   w_last_hs;
    logic                   w_set_overrun;

    // Next-state logic for the multiply/stream sequencer and status flags
    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        tx_byte_d     = tx_byte_q;
        tx_valid_d    = tx_valid_q;
        done_d        = 1'b0;
        w_set_overrun = 1'b0;
`ifdef SPI_MULT_PENDING_BUF_EN
        pbuf_d        = pbuf_q;
        pbuf_valid_d  = pbuf_valid_q;
`endif

        // One partial product per MULT cycle: add A shifted by the bit index
        w_acc_step = acc_q + (b_q[cnt_q] ? ({{OP_WIDTH{1'b0}}, a_q} << cnt_q)
                                         : {c_W2{1'b0}});
        w_hs       = tx_valid_q & tx_ready;
        w_last_hs  = (state_q == S_SEND) && w_hs && (idx_q == c_IW'(c_NB - 1));
        w_idx_next = idx_q + c_IW'(1);
        // Bring the next byte (counting from the MSB end) to the top
        w_byte_shift = acc_q << {w_idx_next, 3'b000};

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    a_d     = rx_data[c_W2-1:OP_WIDTH];
                    b_d     = rx_data[OP_WIDTH-1:0];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_MULT;
                end
            end
            S_MULT: begin
                acc_d = w_acc_step;
                cnt_d = cnt_q + c_CW'(1);
                if (cnt_q == c_CW'(OP_WIDTH - 1)) begin
                    state_d    = S_SEND;
                    idx_d      = '0;
                    tx_byte_d  = w_acc_step[c_W2-1 -: 8];
                    tx_valid_d = 1'b1;
                end
            end
            S_SEND: begin
                if (w_last_hs) begin
                    // tx_byte keeps the last byte sent
                    tx_valid_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
`ifdef SPI_MULT_PENDING_BUF_EN
                    // Chain straight into the next multiply without an idle cycle
                    if (pbuf_valid_q) begin
                        a_d          = pbuf_q[c_W2-1:OP_WIDTH];
                        b_d          = pbuf_q[OP_WIDTH-1:0];
                        acc_d        = '0;
                        cnt_d        = '0;
                        pbuf_valid_d = 1'b0;
                        state_d      = S_MULT;
                    end else if (rx_valid) begin
                        // Empty buffer: the word would be stored and drained on
                        // the same edge, so take it directly as the operands
                        a_d     = rx_data[c_W2-1:OP_WIDTH];
                        b_d     = rx_data[OP_WIDTH-1:0];
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_MULT;
                    end
`endif
                end else if (w_hs) begin
                    idx_d     = w_idx_next;
                    tx_byte_d = w_byte_shift[c_W2-1 -: 8];
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        // Words that arrive while the engine is occupied
        if (rx_valid && (state_q != S_IDLE)) begin
`ifdef SPI_MULT_PENDING_BUF_EN
            if (w_last_hs) begin
                if (pbuf_valid_q) begin
                    pbuf_d       = rx_data;
                    pbuf_valid_d = 1'b1;
                end
            end else if (!pbuf_valid_q) begin
                pbuf_d       = rx_data;
                pbuf_valid_d = 1'b1;
            end else begin
                w_set_overrun = 1'b1;
            end
`else
            w_set_overrun = 1'b1;
`endif
        end

        // A new drop takes priority over a clear request on the same edge
        if (w_set_overrun) begin
            overrun_d = 1'b1;
        end else if (clear_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

`ifdef SPI_MULT_PENDING_BUF_EN
        busy_d = (state_d != S_IDLE) || pbuf_valid_d;
`else
        busy_d = (state_d != S_IDLE);
`endif
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            tx_byte_q    <= '0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SPI_MULT_PENDING_BUF_EN
            pbuf_q       <= '0;
            pbuf_valid_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            tx_byte_q    <= tx_byte_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
`ifdef SPI_MULT_PENDING_BUF_EN
            pbuf_q       <= pbuf_d;
            pbuf_valid_q <= pbuf_valid_d;
`endif
        end
    end

    assign tx_byte  = tx_byte_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_word_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_word_multiplier
// Description : Directed self-checking bench for spi_word_multiplier with
//               hand-computed products (OP_WIDTH = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_word_multiplier;

    logic        clk;
    logic        reset;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;
    logic        overrun;
    logic        clear_overrun;

    int n_checks = 0;
    int n_errors = 0;

    spi_word_multiplier #(.OP_WIDTH(8)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .tx_byte       (tx_byte),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; sample/drive 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w, input logic clr);
        rx_data       = w;
        rx_valid      = 1'b1;
        clear_overrun = clr;
        tick();
        rx_valid      = 1'b0;
        clear_overrun = 1'b0;
    endtask

    // Count edges until tx_valid; exp_lat < 0 skips the latency comparison
    task automatic wait_valid(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!tx_valid && n < 40) begin
            tick();
            n++;
        end
        if (!tx_valid) check({tag, "_timeout"}, 32'(tx_valid), 32'd1);
        else if (exp_lat >= 0) check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    endtask

    // With tx_ready high, collect both product bytes and the done pulse
    task automatic expect_pair(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                               input logic busy_after);
        check({tag, "_byte0"}, 32'(tx_byte), 32'(b0));
        tick();
        check({tag, "_valid1"}, 32'(tx_valid), 32'd1);
        check({tag, "_byte1"}, 32'(tx_byte), 32'(b1));
        tick();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_valid_off"}, 32'(tx_valid), 32'd0);
        check({tag, "_byte_hold"}, 32'(tx_byte), 32'(b1));
        check({tag, "_busy_after"}, 32'(busy), 32'(busy_after));
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        rx_data       = '0;
        rx_valid      = 1'b0;
        tx_ready      = 1'b1;
        clear_overrun = 1'b0;
        tick();
        tick();
        check("rst_tx_byte", 32'(tx_byte), 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        reset = 1'b0;
        tick();

        // 12 * 13 = 156 = 0x009C
        send_word(16'h0C0D, 1'b0);
        check("basic_busy", 32'(busy), 32'd1);
        wait_valid("basic", 8);
        expect_pair("basic", 8'h00, 8'h9C, 1'b0);
        check("basic_overrun", 32'(overrun), 32'd0);

        // 255 * 255 = 65025 = 0xFE01
        send_word(16'hFFFF, 1'b0);
        wait_valid("max", 8);
        expect_pair("max", 8'hFE, 8'h01, 1'b0);

        // 0 * 0
        send_word(16'h0000, 1'b0);
        wait_valid("zero", 8);
        expect_pair("zero", 8'h00, 8'h00, 1'b0);

        // 128 * 2 = 0x0100 under backpressure
        tx_ready = 1'b0;
        send_word(16'h8002, 1'b0);
        wait_valid("bp", 8);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_byte", 32'(tx_byte), 32'h01);
            check("bp_hold_valid", 32'(tx_valid), 32'd1);
            tick();
        end
        tx_ready = 1'b1;
        expect_pair("bp", 8'h01, 8'h00, 1'b0);

`ifdef SPI_MULT_PENDING_BUF_EN
        // 2*2 = 4, then buffered 3*3 = 9 chained without an idle cycle
        send_word(16'h0202, 1'b0);
        tick();
        send_word(16'h0303, 1'b0);
        check("buf_no_overrun", 32'(overrun), 32'd0);
        wait_valid("buf_a", -1);
        expect_pair("buf_a", 8'h00, 8'h04, 1'b1);
        wait_valid("buf_b", 7);
        expect_pair("buf_b", 8'h00, 8'h09, 1'b0);
        check("buf_overrun0", 32'(overrun), 32'd0);
        // Third word while the buffer is full is dropped
        send_word(16'h0101, 1'b0);
        send_word(16'h0202, 1'b0);
        send_word(16'h0303, 1'b0);
        check("buf_full_overrun", 32'(overrun), 32'd1);
        wait_valid("buf_c", -1);
        expect_pair("buf_c", 8'h00, 8'h01, 1'b1);
        wait_valid("buf_d", 7);
        expect_pair("buf_d", 8'h00, 8'h04, 1'b0);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        check("buf_clear", 32'(overrun), 32'd0);
`else
        // 2*2 = 4; 0x0303 arrives during MULT and is dropped
        send_word(16'h0202, 1'b0);
        tick();
        send_word(16'h0303, 1'b0);
        check("ovr_set", 32'(overrun), 32'd1);
        wait_valid("ovr", -1);
        expect_pair("ovr", 8'h00, 8'h04, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("ovr_no_second", 32'(tx_valid), 32'd0);
        // 1*1 = 1; a dropped word with clear on the same edge keeps overrun set
        send_word(16'h0101, 1'b0);
        send_word(16'h0505, 1'b1);
        check("ovr_set_wins", 32'(overrun), 32'd1);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        check("ovr_clear", 32'(overrun), 32'd0);
        wait_valid("ovr2", -1);
        expect_pair("ovr2", 8'h00, 8'h01, 1'b0);
`endif

        // Reset during SEND after the first byte of 0xFE01
        send_word(16'hFFFF, 1'b0);
        wait_valid("rmid", 8);
        check("rmid_byte0", 32'(tx_byte), 32'hFE);
        tick();
        check("rmid_byte1", 32'(tx_byte), 32'h01);
        reset = 1'b1;
        #1;
        check("rmid_tx_byte", 32'(tx_byte), 32'h0);
        check("rmid_tx_valid", 32'(tx_valid), 32'h0);
        check("rmid_busy", 32'(busy), 32'h0);
        check("rmid_done", 32'(done), 32'h0);
        check("rmid_overrun", 32'(overrun), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        check("rmid_no_done", 32'(done), 32'h0);
        // 1 * 2 = 2
        send_word(16'h0102, 1'b0);
        wait_valid("after_rst", 8);
        expect_pair("after_rst", 8'h00, 8'h02, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("after_rst_quiet", 32'(tx_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
